// File: rtl/irq_prio_ctrl_pkg.sv
// Shared register map and vector-format constants for the interrupt controller.
package irq_prio_ctrl_pkg;

    localparam logic [3:0] A_PEND = 4'h0;
    localparam logic [3:0] A_MASK = 4'h1;
    localparam logic [3:0] A_MODE = 4'h2;
    localparam logic [3:0] A_VEC  = 4'h3;
    localparam logic [3:0] A_ISR  = 4'h4;
    localparam logic [3:0] A_CTRL = 4'h5;
    localparam logic [3:0] A_SRC  = 4'h6;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ID_W      = 3;
    localparam int unsigned VALID_BIT = 7;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: reports whether any bit is set and the index of the lowest.
module irq_prio_enc
    import irq_prio_ctrl_pkg::*;
#(
    parameter int unsigned NSRC = 8
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    always_comb begin
        valid = 1'b0;
        id    = '0;
        // Descending scan so the lowest set index is the last one to write.
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Fixed-priority maskable interrupt controller with per-level nesting, vector acknowledge and EOI.
module irq_prio_ctrl
    import irq_prio_ctrl_pkg::*;
#(
    parameter int unsigned NSRC = 8,
    parameter bit          SYNC = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        AD,
    input  logic [7:0]        DI,
    output logic [7:0]        DO,
    input  logic              rw,
    input  logic              cs,
    input  logic [NSRC-1:0]   src,
    output logic              irq
);

    logic [NSRC-1:0]   s;
    logic [NSRC-1:0]   prev_q, pend_q, pend_d, mask_q, mode_q, isr_q, isr_d;
    logic [NSRC-1:0]   act, rise, w1c, ack_clr, cand_oh, top_oh;
    logic              gie_q, irq_q, fire, rd_en, wr_en, ack, eoi;
    logic              cand_valid, top_valid;
    logic [ID_W-1:0]   cand_id, top_id;
    logic [DATA_W-1:0] do_q, do_d;

    if (SYNC) begin : g_sync
        logic [NSRC-1:0] sync1_q, sync2_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= src;
                sync2_q <= sync1_q;
            end
        end
        assign s = sync2_q;
    end else begin : g_nosync
        assign s = src;
    end

    assign act = pend_q & mask_q & ~isr_q;

    irq_prio_enc #(.NSRC(NSRC)) u_enc_act (
        .req   (act),
        .valid (cand_valid),
        .id    (cand_id)
    );

    irq_prio_enc #(.NSRC(NSRC)) u_enc_isr (
        .req   (isr_q),
        .valid (top_valid),
        .id    (top_id)
    );

    // Pre-empt only when the candidate outranks everything already in service.
    assign fire    = gie_q & cand_valid & (~top_valid | (cand_id < top_id));
    assign rd_en   = cs & rw;
    assign wr_en   = cs & ~rw;
    assign ack     = rd_en && (AD == A_VEC) && fire;
    assign eoi     = wr_en && (AD == A_ISR);
    assign cand_oh = NSRC'(1) << cand_id;
    assign top_oh  = NSRC'(1) << top_id;

    always_comb begin
        rise    = s & ~prev_q;
        w1c     = (wr_en && (AD == A_PEND)) ? DI[NSRC-1:0] : '0;
        ack_clr = ack ? cand_oh : '0;
        // Edge bits: clear requests lose to a fresh edge. Level bits track s.
        pend_d  = (mode_q & ((pend_q & ~w1c & ~ack_clr) | rise)) | (~mode_q & s);

        isr_d = isr_q;
        if (ack) begin
            isr_d = isr_d | cand_oh;
        end
        if (eoi && top_valid) begin
            isr_d = isr_d & ~top_oh;
        end

        do_d = do_q;
        if (rd_en) begin
            case (AD)
                A_PEND:  do_d = DATA_W'(pend_q);
                A_MASK:  do_d = DATA_W'(mask_q);
                A_MODE:  do_d = DATA_W'(mode_q);
                A_VEC: begin
                    do_d = '0;
                    if (fire) begin
                        do_d[VALID_BIT]  = 1'b1;
                        do_d[ID_W-1:0]   = cand_id;
                    end
                end
                A_ISR:   do_d = DATA_W'(isr_q);
                A_CTRL:  do_d = {gie_q, 7'b0};
                A_SRC:   do_d = DATA_W'(s);
                default: do_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
            isr_q  <= '0;
            gie_q  <= 1'b0;
            irq_q  <= 1'b0;
            do_q   <= '0;
        end else begin
            prev_q <= s;
            pend_q <= pend_d;
            isr_q  <= isr_d;
            irq_q  <= fire;
            do_q   <= do_d;
            if (wr_en && (AD == A_MASK)) mask_q <= DI[NSRC-1:0];
            if (wr_en && (AD == A_MODE)) mode_q <= DI[NSRC-1:0];
            if (wr_en && (AD == A_CTRL)) gie_q  <= DI[7];
        end
    end

    assign DO  = do_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl with a behavioural reference model checked every cycle.
module tb_irq_prio_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic [7:0] src;
    logic       irq;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    irq_prio_ctrl #(.NSRC(8), .SYNC(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .AD    (AD),
        .DI    (DI),
        .DO    (DO),
        .rw    (rw),
        .cs    (cs),
        .src   (src),
        .irq   (irq)
    );

    // Reference model: src seen two clocks late, rules applied bit by bit.
    logic [7:0] h1, h2, m_prev, m_pend, m_mask, m_mode, m_isr, m_do;
    logic       m_gie, m_irq;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] s, act, np, ni, nd;
        int         c, t;
        bit         fire, ack, eoi, keep;
        if (!rst_n) begin
            h1 <= '0; h2 <= '0; m_prev <= '0; m_pend <= '0; m_mask <= '0;
            m_mode <= '0; m_isr <= '0; m_do <= '0; m_gie <= 1'b0; m_irq <= 1'b0;
        end else begin
            s    = h2;
            act  = m_pend & m_mask & ~m_isr;
            c    = lowest(act);
            t    = lowest(m_isr);
            fire = m_gie && (c < 8) && (c < t);
            ack  = cs && rw && (AD == 4'h3) && fire;
            eoi  = cs && !rw && (AD == 4'h4);
            for (int i = 0; i < 8; i++) begin
                if (!m_mode[i]) begin
                    np[i] = s[i];
                end else begin
                    keep = m_pend[i];
                    if (cs && !rw && AD == 4'h0 && DI[i]) keep = 1'b0;
                    if (ack && i == c) keep = 1'b0;
                    np[i] = keep || (s[i] && !m_prev[i]);
                end
            end
            ni = m_isr;
            if (ack) ni[c[2:0]] = 1'b1;
            if (eoi && t < 8) ni[t[2:0]] = 1'b0;
            nd = m_do;
            if (cs && rw) begin
                case (AD)
                    4'h0:    nd = m_pend;
                    4'h1:    nd = m_mask;
                    4'h2:    nd = m_mode;
                    4'h3:    nd = fire ? (8'h80 | 8'(c)) : 8'h00;
                    4'h4:    nd = m_isr;
                    4'h5:    nd = {m_gie, 7'b0};
                    4'h6:    nd = s;
                    default: nd = 8'h00;
                endcase
            end
            if (cs && !rw && AD == 4'h1) m_mask <= DI;
            if (cs && !rw && AD == 4'h2) m_mode <= DI;
            if (cs && !rw && AD == 4'h5) m_gie  <= DI[7];
            m_pend <= np;
            m_isr  <= ni;
            m_do   <= nd;
            m_irq  <= fire;
            m_prev <= s;
            h2     <= h1;
            h1     <= src;
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (DO !== m_do || irq !== m_irq) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t: DO=%h irq=%b, model DO=%h irq=%b",
                     $time, DO, irq, m_do, m_irq);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
        cs = 1'b1; rw = 1'b1; AD = a;
        @(posedge clk);
        #1;
        cs = 1'b0;
        chk(name, DO, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(posedge clk);
        #1;
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic pulse(input logic [7:0] v);
        src = v;
        idle(1);
        src = 8'h00;
    endtask

    initial begin
        cs = 1'b0; rw = 1'b1; AD = 4'h0; DI = 8'h00; src = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        for (int a = 0; a < 7; a++) begin
            rd(4'(a), 8'h00, "reset_reg");
            chk("reset_irq", {7'b0, irq}, 8'h00);
        end

        // Single edge source
        wr(4'h1, 8'h04);
        wr(4'h2, 8'h04);
        wr(4'h5, 8'h80);
        pulse(8'h04);
        idle(4);
        chk("edge_irq", {7'b0, irq}, 8'h01);
        rd(4'h3, 8'h82, "edge_vec");
        rd(4'h4, 8'h04, "edge_isr");
        chk("edge_irq_after_ack", {7'b0, irq}, 8'h00);
        wr(4'h4, 8'h00);
        rd(4'h4, 8'h00, "edge_isr_eoi");

        // Priority and nesting
        wr(4'h1, 8'hff);
        wr(4'h2, 8'hff);
        pulse(8'h20);
        idle(4);
        chk("nest_irq5", {7'b0, irq}, 8'h01);
        rd(4'h3, 8'h85, "nest_vec5");
        rd(4'h4, 8'h20, "nest_isr5");
        pulse(8'h02);
        idle(4);
        chk("nest_irq1", {7'b0, irq}, 8'h01);
        rd(4'h3, 8'h81, "nest_vec1");
        rd(4'h4, 8'h22, "nest_isr15");
        pulse(8'h40);
        idle(4);
        chk("nest_irq6_blocked", {7'b0, irq}, 8'h00);
        wr(4'h4, 8'h00);
        idle(2);
        chk("nest_irq6_still_blocked", {7'b0, irq}, 8'h00);
        rd(4'h4, 8'h20, "nest_isr_after_eoi1");
        wr(4'h4, 8'h00);
        idle(2);
        chk("nest_irq6_released", {7'b0, irq}, 8'h01);
        rd(4'h3, 8'h86, "nest_vec6");
        wr(4'h4, 8'h00);
        rd(4'h4, 8'h00, "nest_isr_clear");
        rd(4'h0, 8'h00, "nest_pend_clear");

        // Level source
        wr(4'h2, 8'h00);
        wr(4'h1, 8'h01);
        src = 8'h01;
        idle(5);
        chk("level_irq", {7'b0, irq}, 8'h01);
        rd(4'h3, 8'h80, "level_vec");
        rd(4'h4, 8'h01, "level_isr");
        chk("level_irq_in_service", {7'b0, irq}, 8'h00);
        wr(4'h4, 8'h00);
        idle(2);
        chk("level_irq_reassert", {7'b0, irq}, 8'h01);
        rd(4'h3, 8'h80, "level_vec2");
        src = 8'h00;
        idle(5);
        wr(4'h4, 8'h00);
        idle(2);
        chk("level_irq_dropped", {7'b0, irq}, 8'h00);
        rd(4'h0, 8'h00, "level_pend_dropped");

        // W1C racing a new edge: the edge wins
        wr(4'h1, 8'h00);
        wr(4'h2, 8'h08);
        pulse(8'h08);
        idle(1);
        wr(4'h0, 8'h08);
        rd(4'h0, 8'h08, "w1c_race");
        wr(4'h0, 8'h08);
        rd(4'h0, 8'h00, "w1c_plain");

        // Spurious acknowledge
        wr(4'h5, 8'h00);
        wr(4'h1, 8'hff);
        wr(4'h2, 8'hff);
        pulse(8'h10);
        idle(4);
        chk("gie_off_irq", {7'b0, irq}, 8'h00);
        rd(4'h3, 8'h00, "gie_off_vec");
        rd(4'h4, 8'h00, "gie_off_isr");
        rd(4'h0, 8'h10, "gie_off_pend");
        wr(4'h0, 8'hff);
        wr(4'h5, 8'h80);
        rd(4'h5, 8'h80, "ctrl_read");
        idle(2);
        rd(4'h3, 8'h00, "idle_vec");
        rd(4'h4, 8'h00, "idle_isr");

        // Asynchronous reset while in service
        pulse(8'h10);
        idle(4);
        rd(4'h3, 8'h84, "rst_vec4");
        pulse(8'h04);
        idle(4);
        chk("rst_irq_before", {7'b0, irq}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("rst_irq_async", {7'b0, irq}, 8'h00);
        idle(2);
        rst_n = 1'b1;
        rd(4'h4, 8'h00, "rst_isr");
        rd(4'h5, 8'h00, "rst_ctrl");
        rd(4'h1, 8'h00, "rst_mask");
        chk("rst_irq_after", {7'b0, irq}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
